// File: rtl/k16_bus_arbiter.sv
// k16_bus_arbiter: shares the single-port synchronous RAM between K16 CPU
// accesses and VGA scan-out fetches. VGA has priority; a starvation counter
// forces a CPU slot after CPU_STARVE_LIMIT consecutive VGA wins.
// Read data returns one cycle after the grant, when the RAM word appears.
// Optional feature: define ARB_WRITE_BUFFER_EN for a one-entry posted CPU
// write buffer with read forwarding.
module k16_bus_arbiter #(
    parameter int ADDR_WIDTH       = 16,
    parameter int DATA_WIDTH       = 16,
    parameter int CPU_STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_write,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_hold,
    output logic                  cpu_valid,
    input  logic                  vga_req,
    input  logic [ADDR_WIDTH-1:0] vga_address,
    output logic [DATA_WIDTH-1:0] vga_rdata,
    output logic                  vga_valid,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_VGA_BURST, ST_CPU_SLOT} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_CPU_RD, TAG_CPU_WR} tag_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(CPU_STARVE_LIMIT);

    logic [3:0]            starve_cnt;
    logic                  arb_cpu_req;
    logic                  vga_grant;
    logic                  cpu_grant;
    logic                  cpu_accept;
    tag_t                  tag_d;
    tag_t                  tag_q;
    state_t                state;
    logic [DATA_WIDTH-1:0] cpu_rdata_q;
    logic [DATA_WIDTH-1:0] vga_rdata_q;

`ifdef ARB_WRITE_BUFFER_EN
    typedef enum logic [1:0] {SIDE_NONE, SIDE_WR, SIDE_FWD} side_t;

    logic                  wb_full;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  wr_accept;
    logic                  fwd_accept;
    logic                  drain;
    side_t                 side_d;
    side_t                 side_q;
`endif

    // Grant decision, RAM port steering from the winner, and CPU stall
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        mem_address = '0;
        mem_wdata   = '0;
        mem_write   = 1'b0;
        tag_d       = TAG_NONE;
`ifdef ARB_WRITE_BUFFER_EN
        side_d      = SIDE_NONE;
        wr_accept   = !reset && cpu_req && cpu_write && !wb_full;
        fwd_accept  = !reset && cpu_req && !cpu_write && wb_full && (cpu_address == wb_addr);
        // The port is wanted by a pending drain, or by a read once the buffer is empty
        arb_cpu_req = wb_full || (cpu_req && !cpu_write);
`else
        arb_cpu_req = cpu_req;
`endif
        vga_grant = !reset && vga_req && (!arb_cpu_req || (starve_cnt < STARVE_LIMIT));
        cpu_grant = !reset && arb_cpu_req && !vga_grant;

        if (vga_grant) begin
            mem_address = vga_address;
            tag_d       = TAG_VGA;
        end else if (cpu_grant) begin
`ifdef ARB_WRITE_BUFFER_EN
            if (wb_full) begin
                mem_address = wb_addr;
                mem_wdata   = wb_data;
                mem_write   = 1'b1;
            end else begin
                mem_address = cpu_address;
                tag_d       = TAG_CPU_RD;
            end
`else
            mem_address = cpu_address;
            mem_wdata   = cpu_wdata;
            mem_write   = cpu_write;
            tag_d       = cpu_write ? TAG_CPU_WR : TAG_CPU_RD;
`endif
        end

`ifdef ARB_WRITE_BUFFER_EN
        drain = cpu_grant && wb_full;
        if (wr_accept) begin
            side_d = SIDE_WR;
        end else if (fwd_accept) begin
            side_d = SIDE_FWD;
        end
        cpu_accept = (cpu_grant && !wb_full) || wr_accept || fwd_accept;
`else
        cpu_accept = cpu_grant;
`endif
        cpu_hold = reset || (cpu_req && !cpu_accept);
    end

    // Starvation counter, response tag and the observability state machine
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
            tag_q      <= TAG_NONE;
            state      <= ST_IDLE;
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            tag_q <= tag_d;
            if (cpu_grant || !arb_cpu_req) begin
                starve_cnt <= '0;
            end else if (vga_grant && (starve_cnt < STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (vga_grant)      state <= ST_VGA_BURST;
                    else if (cpu_grant) state <= ST_CPU_SLOT;
                end
                ST_VGA_BURST: begin
                    if (cpu_grant)       state <= ST_CPU_SLOT;
                    else if (!vga_grant) state <= ST_IDLE;
                end
                ST_CPU_SLOT: begin
                    if (vga_grant)       state <= ST_VGA_BURST;
                    else if (!cpu_grant) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Remember the last returned words so read-data outputs hold between pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
        end else begin
            if (tag_q == TAG_VGA)    vga_rdata_q <= mem_rdata;
            if (tag_q == TAG_CPU_RD) cpu_rdata_q <= mem_rdata;
`ifdef ARB_WRITE_BUFFER_EN
            if (side_q == SIDE_FWD)  cpu_rdata_q <= fwd_data;
`endif
        end
    end

`ifdef ARB_WRITE_BUFFER_EN
    // Posted write buffer: fill on accepted write, empty on drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_full  <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            fwd_data <= '0;
            side_q   <= SIDE_NONE;
        end else begin
            side_q <= side_d;
            if (fwd_accept) fwd_data <= wb_data;
            if (wr_accept) begin
                wb_full <= 1'b1;
                wb_addr <= cpu_address;
                wb_data <= cpu_wdata;
            end else if (drain) begin
                wb_full <= 1'b0;
            end
        end
    end
`endif

    // Responses: the tag names the owner of the RAM word arriving this cycle
    always_comb begin
        vga_valid = (tag_q == TAG_VGA);
        vga_rdata = vga_valid ? mem_rdata : vga_rdata_q;
        cpu_valid = (tag_q == TAG_CPU_RD) || (tag_q == TAG_CPU_WR);
        cpu_rdata = (tag_q == TAG_CPU_RD) ? mem_rdata : cpu_rdata_q;
`ifdef ARB_WRITE_BUFFER_EN
        if (side_q != SIDE_NONE) cpu_valid = 1'b1;
        if (side_q == SIDE_FWD)  cpu_rdata = fwd_data;
`endif
    end

endmodule
